// File: rtl/net_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | net_pkg: framing constants, header layout, CRC-8 and FSM encoding     |
// | shared by the serial TX and RX blocks.                                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package net_pkg;

  localparam logic [15:0] PREAMBLE_PATTERN = 16'hAAAA;
  localparam logic [7:0]  SFD_PATTERN      = 8'hAB;
  localparam logic [15:0] SYNC_WORD        = {PREAMBLE_PATTERN[7:0], SFD_PATTERN};

  localparam int PKT_W   = 136;
  localparam int HDR_W   = 8;
  localparam int DEST_HI = 7;
  localparam int DEST_LO = 6;
  localparam int SRC_HI  = 5;
  localparam int SRC_LO  = 4;
  localparam int LEN_HI  = 3;
  localparam int LEN_LO  = 0;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_CRC    = 3'd3,
    ST_DONE   = 3'd4
  } rx_state_e;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       din,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_receiver: serial frame receiver with sync hunt, CRC-8 check over   |
// | the payload and destination-ID filtering.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_receiver
  import net_pkg::*;
#(
  parameter logic [1:0] MY_ID    = 2'b01,
  parameter logic [1:0] BCAST_ID = 2'b11,
  parameter logic [7:0] CRC_POLY = CRC8_POLY,
  parameter logic [7:0] CRC_INIT = CRC8_INIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_line,
  output logic [PKT_W-1:0]   rx_packet,
  output logic               rx_valid,
  output logic               crc_err,
  output logic               addr_drop,
  output logic               rx_busy
);

  rx_state_e        state_q, state_d;
  logic [15:0]      win_q, win_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       rx_crc_q, rx_crc_d;
  logic [PKT_W-1:0] rx_packet_q, rx_packet_d;

  logic [7:0] w_last_data_bit;
  logic [1:0] w_dest;
  logic       w_crc_ok;
  logic       w_dest_ok;

  // (len+1)*8-1 == {len,3'b111}; fits in 8 bits for len=15
  assign w_last_data_bit = {1'b0, rx_packet_q[PKT_W-HDR_W+LEN_HI:PKT_W-HDR_W+LEN_LO], 3'b111};
  assign w_dest          = rx_packet_q[PKT_W-HDR_W+DEST_HI:PKT_W-HDR_W+DEST_LO];
  assign w_crc_ok        = (crc_q == rx_crc_q);
  assign w_dest_ok       = (w_dest == MY_ID) || (w_dest == BCAST_ID);

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    bit_cnt_d   = bit_cnt_q;
    crc_d       = crc_q;
    rx_crc_d    = rx_crc_q;
    rx_packet_d = rx_packet_q;

    case (state_q)
      ST_HUNT: begin
        win_d = {win_q[14:0], rx_line};
        if (win_d == SYNC_WORD) begin
          state_d     = ST_HEADER;
          rx_packet_d = '0;
          crc_d       = CRC_INIT;
          bit_cnt_d   = 8'd0;
        end
      end
      ST_HEADER: begin
        rx_packet_d[8'd135 - bit_cnt_q] = rx_line;
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == 8'd7) begin
          state_d   = ST_DATA;
          bit_cnt_d = 8'd0;
        end
      end
      ST_DATA: begin
        rx_packet_d[8'd127 - bit_cnt_q] = rx_line;
        crc_d     = crc8_step(crc_q, rx_line, CRC_POLY);
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == w_last_data_bit) begin
          state_d   = ST_CRC;
          bit_cnt_d = 8'd0;
        end
      end
      ST_CRC: begin
        rx_crc_d  = {rx_crc_q[6:0], rx_line};
        bit_cnt_d = bit_cnt_q + 8'd1;
        if (bit_cnt_q == 8'd7) begin
          state_d   = ST_DONE;
          bit_cnt_d = 8'd0;
        end
      end
      ST_DONE: begin
        state_d = ST_HUNT;
        win_d   = 16'h0000;
      end
      default: begin
        state_d = ST_HUNT;
        win_d   = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      win_q       <= 16'h0000;
      bit_cnt_q   <= 8'd0;
      crc_q       <= CRC_INIT;
      rx_crc_q    <= 8'h00;
      rx_packet_q <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      bit_cnt_q   <= bit_cnt_d;
      crc_q       <= crc_d;
      rx_crc_q    <= rx_crc_d;
      rx_packet_q <= rx_packet_d;
    end
  end

  // The DONE state lasts exactly one cycle, so the verdicts are single pulses
  assign rx_valid  = (state_q == ST_DONE) &&  w_crc_ok &&  w_dest_ok;
  assign addr_drop = (state_q == ST_DONE) &&  w_crc_ok && !w_dest_ok;
  assign crc_err   = (state_q == ST_DONE) && !w_crc_ok;
  assign rx_busy   = (state_q != ST_HUNT);
  assign rx_packet = rx_packet_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_receiver.sv
`default_nettype none
// Directed testbench for rx_receiver: frames are driven bit-serially on the
// falling edge and outputs are checked on the falling edge.
module tb_rx_receiver;

  logic         clk = 1'b0;
  logic         rst;
  logic         rx_line;
  logic [135:0] rx_packet;
  logic         rx_valid;
  logic         crc_err;
  logic         addr_drop;
  logic         rx_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rx_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .rx_line   (rx_line),
    .rx_packet (rx_packet),
    .rx_valid  (rx_valid),
    .crc_err   (crc_err),
    .addr_drop (addr_drop),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  // Drive frame bits [first, stop) of preamble/SFD/header/payload/CRC.
  // stop < 0 sends through the last CRC bit.
  task automatic drive_frame(input logic [7:0] hdr, input logic [127:0] pl,
                             input logic [7:0] crc, input int first, input int stop);
    logic [31:0] head;
    int plen, nbits, last;
    head  = {16'hAAAA, 8'hAB, hdr};
    plen  = (int'(hdr[3:0]) + 1) * 8;
    nbits = 32 + plen + 8;
    last  = (stop < 0) ? nbits : stop;
    for (int i = first; i < last; i++) begin
      @(negedge clk);
      if (i < 32)             rx_line = head[31 - i];
      else if (i < 32 + plen) rx_line = pl[127 - (i - 32)];
      else                    rx_line = crc[7 - (i - 32 - plen)];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_line = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({rx_packet, rx_valid, crc_err, addr_drop, rx_busy} !== 140'd0)
      $display("FAIL reset_outputs: got pkt=%h v=%b e=%b d=%b b=%b, want all 0",
               rx_packet, rx_valid, crc_err, addr_drop, rx_busy);
    else pass_cnt++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    drive_frame(8'h41, {16'h1234, 112'h0}, 8'hF1, 0, -1);
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b000)
      $display("FAIL basic_no_early_pulse: got %b, want 000", {rx_valid, crc_err, addr_drop});
    else pass_cnt++;
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop, rx_busy} !== 4'b1001)
      $display("FAIL basic_pulse: got v/e/d/busy=%b, want 1001", {rx_valid, crc_err, addr_drop, rx_busy});
    else pass_cnt++;
    total_cnt++;
    if (rx_packet !== {8'h41, 16'h1234, 112'h0})
      $display("FAIL basic_packet: got %h, want %h", rx_packet, {8'h41, 16'h1234, 112'h0});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop, rx_busy} !== 4'b0000 || rx_packet !== {8'h41, 16'h1234, 112'h0})
      $display("FAIL basic_after: got v/e/d/busy=%b pkt=%h, want 0000 and packet held",
               {rx_valid, crc_err, addr_drop, rx_busy}, rx_packet);
    else pass_cnt++;
  endtask

  task automatic test_ascii();
    drive_frame(8'h48, {72'h313233343536373839, 56'h0}, 8'hF4, 0, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b100)
      $display("FAIL ascii_pulse: got v/e/d=%b, want 100", {rx_valid, crc_err, addr_drop});
    else pass_cnt++;
    total_cnt++;
    if (rx_packet !== {8'h48, 72'h313233343536373839, 56'h0})
      $display("FAIL ascii_packet: got %h, want %h", rx_packet, {8'h48, 72'h313233343536373839, 56'h0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_crc_error();
    drive_frame(8'h41, {16'h9234, 112'h0}, 8'hF1, 0, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b010)
      $display("FAIL crc_err_pulse: got v/e/d=%b, want 010", {rx_valid, crc_err, addr_drop});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b000)
      $display("FAIL crc_err_one_cycle: got v/e/d=%b, want 000", {rx_valid, crc_err, addr_drop});
    else pass_cnt++;
  endtask

  task automatic test_address();
    drive_frame(8'h81, {16'h1234, 112'h0}, 8'hF1, 0, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b001)
      $display("FAIL addr_drop_pulse: got v/e/d=%b, want 001", {rx_valid, crc_err, addr_drop});
    else pass_cnt++;
    @(negedge clk);
    drive_frame(8'hC1, {16'h1234, 112'h0}, 8'hF1, 0, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b100)
      $display("FAIL bcast_pulse: got v/e/d=%b, want 100", {rx_valid, crc_err, addr_drop});
    else pass_cnt++;
    total_cnt++;
    if (rx_packet !== {8'hC1, 16'h1234, 112'h0})
      $display("FAIL bcast_packet: got %h, want %h", rx_packet, {8'hC1, 16'h1234, 112'h0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    drive_frame(8'h41, {16'h1234, 112'h0}, 8'hF1, 0, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if (rx_valid !== 1'b1 || rx_packet !== {8'h41, 16'h1234, 112'h0})
      $display("FAIL b2b_first: got v=%b pkt=%h, want 1 and %h",
               rx_valid, rx_packet, {8'h41, 16'h1234, 112'h0});
    else pass_cnt++;
    @(negedge clk);
    rx_line = 1'b1;
    total_cnt++;
    if (rx_busy !== 1'b0)
      $display("FAIL b2b_busy_gap: got busy=%b, want 0", rx_busy);
    else pass_cnt++;
    drive_frame(8'h40, 128'h0, 8'h00, 1, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b100 || rx_packet !== {8'h40, 128'h0})
      $display("FAIL b2b_second: got v/e/d=%b pkt=%h, want 100 and %h",
               {rx_valid, crc_err, addr_drop}, rx_packet, {8'h40, 128'h0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    logic seen;
    drive_frame(8'h41, {16'h1234, 112'h0}, 8'hF1, 0, 40);
    @(negedge clk);
    rst = 1'b1;
    rx_line = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    total_cnt++;
    if ({rx_packet, rx_valid, crc_err, addr_drop, rx_busy} !== 140'd0)
      $display("FAIL midrst_outputs: got pkt=%h v=%b e=%b d=%b b=%b, want all 0",
               rx_packet, rx_valid, crc_err, addr_drop, rx_busy);
    else pass_cnt++;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (rx_valid || crc_err || addr_drop || rx_busy) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0)
      $display("FAIL midrst_no_pulse: got activity=%b, want 0", seen);
    else pass_cnt++;
    drive_frame(8'h41, {16'h1234, 112'h0}, 8'hF1, 0, -1);
    @(negedge clk);
    rx_line = 1'b0;
    total_cnt++;
    if ({rx_valid, crc_err, addr_drop} !== 3'b100 || rx_packet !== {8'h41, 16'h1234, 112'h0})
      $display("FAIL midrst_next_frame: got v/e/d=%b pkt=%h, want 100 and %h",
               {rx_valid, crc_err, addr_drop}, rx_packet, {8'h41, 16'h1234, 112'h0});
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ascii();
    test_crc_error();
    test_address();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
